// File: rtl/mem_wb_stage_pkg.sv
// Shared types and helpers for the memory stage and MEM/WB pipeline register.
package mem_wb_stage_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef enum logic [1:0] {
      BHC_WORD = 2'd0,
      BHC_HALF = 2'd1,
      BHC_BYTE = 2'd2
   } bhc_e;

   // Payload carried from MEM into WB.
   typedef struct packed {
      logic              regwrite;
      logic              memtoreg;
      logic [REG_W-1:0]  regdst;
      logic [WORD_W-1:0] readdata;
      logic [WORD_W-1:0] aluresult;
      logic              misalign;
   } mem_wb_t;

   // Size code 3 behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] bhc, input logic [1:0] lane);
      logic mis;
      mis = 1'b0;
      case (bhc)
         2'(BHC_HALF): mis = lane[0];
         2'(BHC_BYTE): mis = 1'b0;
         default:      mis = (lane != 2'd0);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM-side inputs and WB-side outputs of the memory stage.
interface mem_wb_stage_if;
   import mem_wb_stage_pkg::*;

   logic              RegWrite_in;
   logic              MemWrite_in;
   logic              MemRead_in;
   logic              MemToReg_in;
   logic [REG_W-1:0]  RegDst_in;
   logic [WORD_W-1:0] ALUResult_in;
   logic [WORD_W-1:0] WriteData_in;
   logic [1:0]        BHC_in;

   logic              RegWrite_out;
   logic              MemToReg_out;
   logic [REG_W-1:0]  RegDst_out;
   logic [WORD_W-1:0] ReadData_out;
   logic [WORD_W-1:0] ALUResult_out;
   logic [WORD_W-1:0] WriteBackData_out;
   logic              Misalign_out;

   modport master (
      output RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in,
             RegDst_in, ALUResult_in, WriteData_in, BHC_in,
      input  RegWrite_out, MemToReg_out, RegDst_out, ReadData_out,
             ALUResult_out, WriteBackData_out, Misalign_out
   );

   modport slave (
      input  RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in,
             RegDst_in, ALUResult_in, WriteData_in, BHC_in,
      output RegWrite_out, MemToReg_out, RegDst_out, ReadData_out,
             ALUResult_out, WriteBackData_out, Misalign_out
   );

endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// Word-organised data memory: byte-enabled synchronous write, asynchronous read.
module data_memory #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata_c
);

   logic [3:0][7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory access (sized loads/stores, sign extension, misalign detection) plus
// the MEM/WB pipeline register and write-back data mux.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input logic           Clk,
   input logic           reset_n,
   mem_wb_stage_if.slave bus
);

   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic              mis;
   logic              we;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       rdata_c;
   logic [7:0]        rbyte;
   logic [15:0]       rhalf;
   logic [31:0]       load_data;
   mem_wb_t           nxt;
   mem_wb_t           q;

   assign idx  = bus.ALUResult_in[ADDR_W+1:2];
   assign lane = bus.ALUResult_in[1:0];

   data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dmem (
      .clk     (Clk),
      .we      (we),
      .addr    (idx),
      .be      (be),
      .wdata   (wdata),
      .rdata_c (rdata_c)
   );

   // Store lane steering; a store coinciding with reset is suppressed.
   always_comb begin
      be    = 4'h0;
      wdata = bus.WriteData_in;
      mis   = is_misaligned(bus.BHC_in, lane);
      we    = bus.MemWrite_in & reset_n & ~mis;
      case (bus.BHC_in)
         2'(BHC_BYTE): begin
            be    = 4'(4'b0001 << lane);
            wdata = {4{bus.WriteData_in[7:0]}};
         end
         2'(BHC_HALF): begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{bus.WriteData_in[15:0]}};
         end
         default: be = 4'hF;
      endcase
   end

   // Load lane select and sign extension.
   always_comb begin
      rbyte     = rdata_c[8*lane +: 8];
      rhalf     = lane[1] ? rdata_c[31:16] : rdata_c[15:0];
      load_data = rdata_c;
      case (bus.BHC_in)
         2'(BHC_BYTE): load_data = {{24{rbyte[7]}}, rbyte};
         2'(BHC_HALF): load_data = {{16{rhalf[15]}}, rhalf};
         default:      load_data = rdata_c;
      endcase
   end

   always_comb begin
      nxt           = '0;
      nxt.regwrite  = bus.RegWrite_in & ~(bus.MemRead_in & mis);
      nxt.memtoreg  = bus.MemToReg_in;
      nxt.regdst    = bus.RegDst_in;
      nxt.readdata  = (bus.MemRead_in && !mis) ? load_data : '0;
      nxt.aluresult = bus.ALUResult_in;
      nxt.misalign  = (bus.MemRead_in | bus.MemWrite_in) & mis;
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= nxt;
   end

   assign bus.RegWrite_out      = q.regwrite;
   assign bus.MemToReg_out      = q.memtoreg;
   assign bus.RegDst_out        = q.regdst;
   assign bus.ReadData_out      = q.readdata;
   assign bus.ALUResult_out     = q.aluresult;
   assign bus.Misalign_out      = q.misalign;
   assign bus.WriteBackData_out = q.memtoreg ? q.readdata : q.aluresult;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected WB values queued at issue, checked one cycle later.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   mem_wb_stage_if bus ();

   mem_wb_stage #(.DEPTH(256), .ADDR_W(8)) dut (
      .Clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] wb;
      logic [31:0] alu;
      logic [4:0]  dst;
      logic        rw;
      logic        m2r;
      logic        mis;
   } exp_t;

   exp_t sb [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic mw, input logic mr, input logic m2r,
                        input logic [4:0] dst, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [1:0] bhc);
      bus.RegWrite_in  = rw;
      bus.MemWrite_in  = mw;
      bus.MemRead_in   = mr;
      bus.MemToReg_in  = m2r;
      bus.RegDst_in    = dst;
      bus.ALUResult_in = alu;
      bus.WriteData_in = wd;
      bus.BHC_in       = bhc;
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, ".rd"},  bus.ReadData_out,          e.rd);
      check({tag, ".wb"},  bus.WriteBackData_out,     e.wb);
      check({tag, ".alu"}, bus.ALUResult_out,         e.alu);
      check({tag, ".dst"}, 32'(bus.RegDst_out),       32'(e.dst));
      check({tag, ".rw"},  32'(bus.RegWrite_out),     32'(e.rw));
      check({tag, ".m2r"}, 32'(bus.MemToReg_out),     32'(e.m2r));
      check({tag, ".mis"}, 32'(bus.Misalign_out),     32'(e.mis));
   endtask

   // One transaction: drive at negedge, push expectation, compare after the edge.
   task automatic issue(input string tag, input logic rw, input logic mw, input logic mr,
                        input logic m2r, input logic [4:0] dst, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [1:0] bhc,
                        input logic [31:0] e_rd, input logic e_rw, input logic e_mis);
      exp_t e;
      exp_t got_e;
      @(negedge clk);
      drive(rw, mw, mr, m2r, dst, alu, wd, bhc);
      e.rd  = e_rd;
      e.wb  = m2r ? e_rd : alu;
      e.alu = alu;
      e.dst = dst;
      e.rw  = e_rw;
      e.m2r = m2r;
      e.mis = e_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         got_e = sb.pop_front();
         check_outputs(tag, got_e);
      end
   endtask

   localparam logic [1:0] W = 2'd0;
   localparam logic [1:0] H = 2'd1;
   localparam logic [1:0] B = 2'd2;

   exp_t zero_e;

   initial begin
      zero_e = '{rd: 32'd0, wb: 32'd0, alu: 32'd0, dst: 5'd0, rw: 1'b0, m2r: 1'b0, mis: 1'b0};
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, W);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("por", zero_e);
      @(negedge clk);
      reset_n = 1'b1;

      //            tag        rw mw mr m2r dst   alu           wd            bhc  e_rd          e_rw e_mis
      issue("clr10",    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h10,  32'h0,        W, 32'h0,        1'b0, 1'b0);
      issue("alu0",     1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0,       W, 32'h0,        1'b1, 1'b0);

      // Reset mid-stream while a store to 0x10 is presented.
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h10, 32'hCAFEF00D, W);
      reset_n = 1'b0;
      #1;
      check_outputs("rst_async", zero_e);
      @(posedge clk);
      #1;
      check_outputs("rst_hold", zero_e);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, W);

      issue("ld10",     1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h10,  32'h0,        W, 32'h0,        1'b1, 1'b0);
      issue("stw20",    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h20,  32'hDEADBEEF, W, 32'h0,        1'b0, 1'b0);
      issue("ldw20",    1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h20,  32'h0,        W, 32'hDEADBEEF, 1'b1, 1'b0);
      issue("stb21",    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h21,  32'h12345680, B, 32'h0,        1'b0, 1'b0);
      issue("ldb21",    1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h21,  32'h0,        B, 32'hFFFFFF80, 1'b1, 1'b0);
      issue("ldw20b",   1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h20,  32'h0,        W, 32'hDEAD80EF, 1'b1, 1'b0);
      issue("sth22",    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h22,  32'hABCD7FFF, H, 32'h0,        1'b0, 1'b0);
      issue("ldh22",    1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h22,  32'h0,        H, 32'h00007FFF, 1'b1, 1'b0);
      issue("ldw20h",   1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h20,  32'h0,        W, 32'h7FFF80EF, 1'b1, 1'b0);
      issue("ldh20",    1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h20,  32'h0,        H, 32'hFFFF80EF, 1'b1, 1'b0);
      issue("ldb23",    1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h23,  32'h0,        B, 32'h0000007F, 1'b1, 1'b0);
      issue("misldw23", 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h23,  32'h0,        W, 32'h0,        1'b0, 1'b1);
      issue("missth21", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h21,  32'h5555,     H, 32'h0,        1'b0, 1'b1);
      issue("ldw20m",   1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h20,  32'h0,        W, 32'h7FFF80EF, 1'b1, 1'b0);
      issue("misldh21", 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h21,  32'h0,        H, 32'h0,        1'b0, 1'b1);
      issue("alu1234",  1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 32'h1234, 32'h0,      W, 32'h0,        1'b1, 1'b0);
      issue("alu_odd",  1'b1, 1'b0, 1'b0, 1'b0, 5'd11, 32'h3,  32'h0,        W, 32'h0,        1'b1, 1'b0);
      issue("alias420", 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h420, 32'h0,       W, 32'h7FFF80EF, 1'b1, 1'b0);
      issue("stw424",   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h424, 32'h01020304, W, 32'h0,        1'b0, 1'b0);
      issue("ldw24",    1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h24, 32'h0,        W, 32'h01020304, 1'b1, 1'b0);
      issue("bhc3w",    1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 32'h20, 32'h0,     2'd3, 32'h7FFF80EF, 1'b1, 1'b0);
      issue("bhc3mis",  1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 32'h22, 32'h0,     2'd3, 32'h0,        1'b0, 1'b1);
      issue("rdwr24",   1'b1, 1'b1, 1'b1, 1'b1, 5'd15, 32'h24, 32'hAAAAAAAA, W, 32'h01020304, 1'b1, 1'b0);
      issue("ldw24b",   1'b1, 1'b0, 1'b1, 1'b1, 5'd16, 32'h24, 32'h0,        W, 32'hAAAAAAAA, 1'b1, 1'b0);
      issue("stb27",    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h27,  32'h00000011, B, 32'h0,        1'b0, 1'b0);
      issue("ldw24c",   1'b1, 1'b0, 1'b1, 1'b1, 5'd17, 32'h24, 32'h0,        W, 32'h11AAAAAA, 1'b1, 1'b0);
      issue("nord",     1'b1, 1'b0, 1'b0, 1'b1, 5'd18, 32'h24, 32'h0,        W, 32'h0,        1'b1, 1'b0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register for the five-stage MIPS datapath.
- Sits directly downstream of the EX/MEM register and consumes its outputs: RegWrite, MemWrite, MemRead, MemToReg, RegDst, ALUResult, readData2 and BHC.
- Owns the data memory. Performs byte/halfword/word stores and loads with sign extension, and flags misaligned accesses.
- Registers the results for write-back and drives the final write-back data mux.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory; must be a power of 2.
- ADDR_W, 8, word-index width; equals log2(DEPTH).

Ports:
- Clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- RegWrite_in  in  1  register-file write enable from EX/MEM.
- MemWrite_in  in  1  store enable from EX/MEM.
- MemRead_in  in  1  load enable from EX/MEM.
- MemToReg_in  in  1  write-back source select from EX/MEM: 1 = memory, 0 = ALU.
- RegDst_in  in  5  destination register number from EX/MEM.
- ALUResult_in  in  32  byte address for loads/stores, and the ALU result for write-back.
- WriteData_in  in  32  store data (readData2 from EX/MEM).
- BHC_in  in  2  access size: 0 = word, 1 = halfword, 2 = byte, 3 = treated as word.
- RegWrite_out  out  1  registered write enable to the register file.
- MemToReg_out  out  1  registered write-back select.
- RegDst_out  out  5  registered destination register.
- ReadData_out  out  32  registered, aligned and sign-extended load data.
- ALUResult_out  out  32  registered ALU result.
- WriteBackData_out  out  32  combinational: MemToReg_out ? ReadData_out : ALUResult_out.
- Misalign_out  out  1  registered one-cycle flag: the instruction now in WB made a misaligned access.

Behaviour:
- Reset (reset_n low, asynchronous): all *_out registers clear to 0, so WriteBackData_out = 0. Memory contents are not reset; simulation initialises them to 0. Reset asserted mid-operation: a store presented on the same edge is not performed.
- Addressing:
  - Word index = ALUResult_in[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = ALUResult_in[1:0], little-endian: lane 0 = bits 7:0.
- Misalignment:
  - Halfword access with addr[0] = 1, or word access with addr[1:0] != 0.
  - Misaligned store: memory is unchanged.
  - Misaligned load: ReadData_out = 0 and RegWrite_out is forced to 0.
  - Misalign_out = 1 only when MemRead_in or MemWrite_in is set; otherwise 0.
- Stores: on posedge with MemWrite_in = 1, reset_n = 1 and access aligned, write with byte enables.
  - Byte: lane = WriteData_in[7:0].
  - Halfword: lanes addr[1]*2 and +1 = WriteData_in[15:0].
  - Word: all four lanes.
  - Other bytes of the word are preserved.
- Loads: combinational array read, then lane select.
  - Byte: sign-extended from bit 7.
  - Halfword: sign-extended from bit 15.
  - Word: raw.
  - Result registered into ReadData_out on posedge.
  - MemRead_in = 0: ReadData_out = 0.
- Latency: one cycle from inputs to *_out. A load's data appears in WB on the cycle after it is in MEM.
- Store followed by load to the same address on the next cycle: the load returns the newly stored data (write-first across cycles).
- MemRead_in and MemWrite_in both 1: illegal from decode. Store happens, load data is captured from the pre-write array contents.
- No stall/flush inputs. The stage advances every cycle.

Decomposition:
- Shared package:
  - BHC encodings BHC_WORD = 2'd0, BHC_HALF = 2'd1, BHC_BYTE = 2'd2.
  - Word/register widths: 32 and 5.
- One sub-module, data_memory: byte-enabled synchronous write, asynchronous read, DEPTH/ADDR_W parameters.
- Lane select, sign extension, misalignment check and pipeline registers stay in mem_wb_stage.

Test Plan:
- Reset: hold reset_n = 0 mid-stream with MemWrite_in = 1 at addr 0x10 -> all outputs 0; a later word load of 0x10 returns 0.
- Word store 0xDEADBEEF to 0x20, then next cycle word load 0x20 with MemToReg_in = 1, RegDst_in = 5 -> next cycle ReadData_out = WriteBackData_out = 0xDEADBEEF, RegDst_out = 5, RegWrite_out = 1.
- Byte store 0x80 to 0x21, then byte load 0x21 -> 0xFFFFFF80; word load 0x20 -> 0xDEAD80EF.
- Halfword store 0x7FFF to 0x22, then halfword load 0x22 -> 0x00007FFF; word load 0x20 -> 0x7FFF80EF.
- Misaligned word load at 0x23 with RegWrite_in = 1 -> Misalign_out = 1, RegWrite_out = 0, ReadData_out = 0. Misaligned halfword store at 0x21 -> memory unchanged, Misalign_out = 1.
- ALU op (MemToReg_in = 0, ALUResult_in = 0x1234) -> WriteBackData_out = 0x1234, Misalign_out = 0. Address 0x420 with DEPTH = 256 aliases to 0x020.
